// File: rtl/fft_frame_streamer.sv
// Frame source/sink for the FFT core: replays one buffered complex frame as 2^step-sample frames and counts returned frames.
// First sample two cycles after an accepted start; no backpressure (core takes every beat), abort stops the run at the next edge.

module fft_frame_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_STEP   = 9,
  parameter int GAP_W      = 8
) (
  input  logic                  iclk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [MAX_STEP-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_real,
  input  logic [DATA_WIDTH-1:0] wr_imag,
  input  logic [3:0]            cfg_step,
  input  logic [GAP_W-1:0]      cfg_gap,
  input  logic [7:0]            cfg_frames,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  s_en,
  output logic [DATA_WIDTH-1:0] s_real,
  output logic [DATA_WIDTH-1:0] s_imag,
  output logic                  s_last,
  input  logic                  r_en,
  output logic                  rx_last,
  output logic [15:0]           rx_frames
);

  localparam int         DEPTH    = 1 << MAX_STEP;
  localparam logic [3:0] MIN_STEP = 4'd3;
  localparam logic [3:0] TOP_STEP = 4'(MAX_STEP);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } sample_t;

  typedef enum logic [1:0] {IDLE, STREAM, GAP, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [MAX_STEP-1:0]   addr_q, addr_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [7:0]            frm_cnt_q, frm_cnt_d;
  logic [7:0]            frames_q, frames_d;
  logic [3:0]            step_q, step_d;
  logic [3:0]            step_clamp;
  logic [MAX_STEP-1:0]   last_addr;
  logic                  done_q, done_d;
  logic                  rd_issue, rd_issue_last, start_acc;
  logic                  rd_vld_q, rd_last_q;
  logic                  s_en_q, s_last_q;
  logic [DATA_WIDTH-1:0] s_real_q, s_imag_q;
  logic [MAX_STEP-1:0]   rx_beat_q;
  logic                  rx_last_q;
  logic [15:0]           rx_frames_q;

  sample_t mem [DEPTH];
  sample_t rd_dat_q;

  always_comb begin
    step_clamp = cfg_step;
    if (cfg_step < MIN_STEP)      step_clamp = MIN_STEP;
    else if (cfg_step > TOP_STEP) step_clamp = TOP_STEP;
  end

  // All-ones mask of the frame length minus one; also the monitor's wrap point.
  assign last_addr = ~({MAX_STEP{1'b1}} << step_q);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    gap_cnt_d     = gap_cnt_q;
    frm_cnt_d     = frm_cnt_q;
    frames_d      = frames_q;
    gap_d         = gap_q;
    step_d        = step_q;
    done_d        = 1'b0;
    rd_issue      = 1'b0;
    rd_issue_last = 1'b0;
    start_acc     = 1'b0;
    if (abort) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            start_acc = 1'b1;
            state_d   = STREAM;
            addr_d    = '0;
            frm_cnt_d = '0;
            step_d    = step_clamp;
            gap_d     = cfg_gap;
            frames_d  = cfg_frames;
          end
        end
        STREAM: begin
          rd_issue = 1'b1;
          if (addr_q == last_addr) begin
            rd_issue_last = 1'b1;
            addr_d        = '0;
            frm_cnt_d     = frm_cnt_q + 8'd1;
            if (frames_q != 8'd0 && (frm_cnt_q + 8'd1) == frames_q) begin
              state_d   = DRAIN;
              gap_cnt_d = GAP_W'(1);
            end else if (gap_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q - GAP_W'(1);
            end
          end else begin
            addr_d = addr_q + MAX_STEP'(1);
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) state_d = STREAM;
          else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
        DRAIN: begin
          // Two cycles let the buffer read and output register empty before done.
          if (gap_cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Buffer is not reset; read-first on a same-address write.
  always_ff @(posedge iclk) begin
    if (wr_en) mem[wr_addr] <= '{re: wr_real, im: wr_imag};
    rd_dat_q <= mem[addr_q];
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      gap_cnt_q <= '0;
      frm_cnt_q <= '0;
      frames_q  <= '0;
      gap_q     <= '0;
      step_q    <= MIN_STEP;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      s_en_q    <= 1'b0;
      s_last_q  <= 1'b0;
      s_real_q  <= '0;
      s_imag_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      gap_cnt_q <= gap_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      frames_q  <= frames_d;
      gap_q     <= gap_d;
      step_q    <= step_d;
      done_q    <= done_d;
      rd_vld_q  <= rd_issue;
      rd_last_q <= rd_issue_last;
      s_en_q    <= rd_vld_q & ~abort;
      s_last_q  <= rd_last_q & ~abort;
      if (rd_vld_q) begin
        s_real_q <= rd_dat_q.re;
        s_imag_q <= rd_dat_q.im;
      end
    end
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      rx_beat_q   <= '0;
      rx_last_q   <= 1'b0;
      rx_frames_q <= '0;
    end else if (start_acc) begin
      rx_beat_q   <= '0;
      rx_last_q   <= 1'b0;
      rx_frames_q <= '0;
    end else begin
      rx_last_q <= 1'b0;
      if (r_en) begin
        if (rx_beat_q == last_addr) begin
          rx_beat_q <= '0;
          rx_last_q <= 1'b1;
          if (rx_frames_q != 16'hFFFF) rx_frames_q <= rx_frames_q + 16'd1;
        end else begin
          rx_beat_q <= rx_beat_q + MAX_STEP'(1);
        end
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign s_en      = s_en_q;
  assign s_last    = s_last_q;
  assign s_real    = s_real_q;
  assign s_imag    = s_imag_q;
  assign rx_last   = rx_last_q;
  assign rx_frames = rx_frames_q;

endmodule
